// File: rtl/uart_tx_queue.sv
// uart_tx_queue: byte FIFO plus send sequencer sitting directly upstream of
// serial_tx. Producers write bursts without polling busy; the sequencer pops
// one byte at a time, pulses tx_send for one cycle, follows tx_busy through the
// frame and then waits GUARD cycles (one stop-bit time) before the next send.
//
// Parameters:
//   DEPTH_LOG2  FIFO depth = 2**DEPTH_LOG2 bytes
//   GUARD       clk cycles of idle line after tx_busy falls
//
// Ports:
//   clk, reset   system clock; asynchronous active-high reset
//   wr_en        write strobe (dropped when full, unless a pop frees a slot)
//   wr_data      byte to queue
//   full, empty  FIFO occupancy flags
//   tx_sbyte     byte for serial_tx, held until the next pop
//   tx_send      one-cycle send pulse to serial_tx
//   tx_busy      busy from serial_tx
//   idle         queue empty, sequencer idle, line not busy
//   level        occupancy                         (UART_TXQ_STATUS_EN)
//   overflow     sticky: a write was dropped       (UART_TXQ_STATUS_EN)
//   ovf_clr      clears overflow; a same-cycle set wins (UART_TXQ_STATUS_EN)
//
// Build option: define UART_TXQ_STATUS_EN to add level/overflow/ovf_clr.

module uart_tx_queue #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned GUARD      = 209
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       full,
  output logic       empty,
  output logic [7:0] tx_sbyte,
  output logic       tx_send,
  input  logic       tx_busy,
  output logic       idle
`ifdef UART_TXQ_STATUS_EN
  ,
  output logic [DEPTH_LOG2:0] level,
  output logic                overflow,
  input  logic                ovf_clr
`endif
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned PW    = DEPTH_LOG2 + 1;
  localparam int unsigned TW    = ($clog2(GUARD + 1) < 2) ? 2 : $clog2(GUARD + 1);
  localparam logic [PW-1:0] FULL_CNT = PW'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_HI,
    S_WAIT_LO,
    S_GUARD
  } state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] tmr, tmr_nxt;
  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, count;
  logic          pop, push;

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);
  // A pop in the same cycle frees the slot, so a write while full is taken.
  assign push  = wr_en & (~full | pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      tx_sbyte <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr   <= rd_ptr + PW'(1);
        tx_sbyte <= mem[rd_ptr[DEPTH_LOG2-1:0]];
      end
      if (push && !pop)      count <= count + PW'(1);
      else if (pop && !push) count <= count - PW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      tmr   <= '0;
    end else begin
      state <= state_nxt;
      tmr   <= tmr_nxt;
    end
  end

  // tmr doubles as the 4-cycle tx_busy-rise timeout and the guard counter.
  always_comb begin
    state_nxt = state;
    tmr_nxt   = tmr;
    pop       = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty && !tx_busy) begin
          pop       = 1'b1;
          state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        tmr_nxt   = TW'(3);
        state_nxt = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (tx_busy || tmr == '0) state_nxt = S_WAIT_LO;
        else                      tmr_nxt   = tmr - TW'(1);
      end
      S_WAIT_LO: begin
        if (!tx_busy) begin
          tmr_nxt   = TW'(GUARD);
          state_nxt = S_GUARD;
        end
      end
      S_GUARD: begin
        if (tmr == '0) state_nxt = S_IDLE;
        else           tmr_nxt   = tmr - TW'(1);
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign tx_send = (state == S_SEND);
  assign idle    = empty & (state == S_IDLE) & ~tx_busy;

`ifdef UART_TXQ_STATUS_EN
  assign level = count;

  // Only a write that is actually dropped flags overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                        overflow <= 1'b0;
    else if (wr_en && full && !pop)   overflow <= 1'b1;
    else if (ovf_clr)                 overflow <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
module tb_uart_tx_queue;

  localparam int unsigned GUARD_T = 209;
  localparam int unsigned FRAME   = 20;

  logic       clk;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       empty;
  logic [7:0] tx_sbyte;
  logic       tx_send;
  logic       tx_busy;
  logic       idle;
`ifdef UART_TXQ_STATUS_EN
  logic [4:0] level;
  logic       overflow;
  logic       ovf_clr;
`endif

  uart_tx_queue #(.DEPTH_LOG2(4), .GUARD(GUARD_T)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .tx_sbyte (tx_sbyte),
    .tx_send  (tx_send),
    .tx_busy  (tx_busy),
    .idle     (idle)
`ifdef UART_TXQ_STATUS_EN
    ,
    .level    (level),
    .overflow (overflow),
    .ovf_clr  (ovf_clr)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // serial_tx stand-in: busy rises the cycle after send, stays FRAME cycles.
  logic        model_en   = 1'b1;
  logic        busy_force = 1'b0;
  logic        mbusy;
  int unsigned mcnt;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mbusy <= 1'b0;
      mcnt  <= 0;
    end else if (tx_send && model_en) begin
      mbusy <= 1'b1;
      mcnt  <= FRAME - 1;
    end else if (mbusy) begin
      if (mcnt == 0) mbusy <= 1'b0;
      else           mcnt  <= mcnt - 1;
    end
  end
  assign tx_busy = mbusy | busy_force;

  logic [7:0]  sent_q[$];
  int unsigned send_cyc[$];
  int unsigned fall_cyc[$];
  int unsigned viol = 0;
  logic        prev_busy = 1'b0;
  always @(negedge clk) begin
    if (tx_send === 1'b1) begin
      sent_q.push_back(tx_sbyte);
      send_cyc.push_back(cyc);
      if (tx_busy) viol++;
    end
    if (prev_busy && !tx_busy) fall_cyc.push_back(cyc);
    prev_busy = tx_busy;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic clear_log();
    sent_q.delete();
    send_cyc.delete();
    fall_cyc.delete();
    viol = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wr_en = 1'b0;
    wr_data = 8'h00;
`ifdef UART_TXQ_STATUS_EN
    ovf_clr = 1'b0;
`endif
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_idle(input int unsigned limit, output bit ok);
    ok = 1'b0;
    for (int unsigned i = 0; i < limit; i++) begin
      @(negedge clk);
      if (idle === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (tx_send !== 1'b0) begin n_err++; $display("FAIL reset_tx_send got=%b want=0", tx_send); end
    n_cmp++; if (tx_sbyte !== 8'h00) begin n_err++; $display("FAIL reset_tx_sbyte got=%h want=00", tx_sbyte); end
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty got=%b want=1", empty); end
    n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL reset_full got=%b want=0", full); end
    n_cmp++; if (idle !== 1'b1) begin n_err++; $display("FAIL reset_idle got=%b want=1", idle); end
`ifdef UART_TXQ_STATUS_EN
    n_cmp++; if (level !== 5'd0) begin n_err++; $display("FAIL reset_level got=%0d want=0", level); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow got=%b want=0", overflow); end
`endif
  endtask

  task automatic test_single_latency();
    bit ok;
    clear_log();
    @(negedge clk);
    wr_en = 1'b1; wr_data = 8'hA5;
    @(negedge clk);
    wr_en = 1'b0;
    n_cmp++; if (empty !== 1'b0) begin n_err++; $display("FAIL lat_empty_after_wr got=%b want=0", empty); end
    n_cmp++; if (tx_send !== 1'b0) begin n_err++; $display("FAIL lat_early_send got=%b want=0", tx_send); end
    @(negedge clk);
    n_cmp++; if (tx_send !== 1'b1) begin n_err++; $display("FAIL lat_send got=%b want=1", tx_send); end
    n_cmp++; if (tx_sbyte !== 8'hA5) begin n_err++; $display("FAIL lat_sbyte got=%h want=a5", tx_sbyte); end
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL lat_empty_after_pop got=%b want=1", empty); end
    repeat (3) @(negedge clk);
    n_cmp++; if (tx_send !== 1'b0) begin n_err++; $display("FAIL lat_pulse_width got=%b want=0", tx_send); end
    n_cmp++; if (tx_sbyte !== 8'hA5) begin n_err++; $display("FAIL lat_sbyte_hold got=%h want=a5", tx_sbyte); end
    wait_idle(FRAME + GUARD_T + 50, ok);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL lat_drain_timeout idle=%b want=1", idle); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    clear_log();
    for (int unsigned k = 1; k <= 5; k++) begin
      @(negedge clk);
      wr_en = 1'b1; wr_data = 8'(k);
    end
    @(negedge clk);
    wr_en = 1'b0;
    for (int unsigned i = 0; i < 5 * (FRAME + GUARD_T + 20) && sent_q.size() < 5; i++) @(posedge clk);
    n_cmp++; if (sent_q.size() != 5) begin n_err++; $display("FAIL b2b_count got=%0d want=5", sent_q.size()); end
    if (sent_q.size() == 5 && fall_cyc.size() >= 4) begin
      for (int unsigned k = 0; k < 5; k++) begin
        n_cmp++; if (sent_q[k] !== 8'(k + 1)) begin n_err++; $display("FAIL b2b_byte%0d got=%h want=%h", k, sent_q[k], 8'(k + 1)); end
      end
      // busy low at cycle w -> GUARD loads at w+1, counts 210 cycles, IDLE pop, send.
      for (int unsigned k = 1; k < 5; k++) begin
        n_cmp++;
        if (send_cyc[k] - fall_cyc[k-1] != GUARD_T + 3) begin
          n_err++; $display("FAIL b2b_guard%0d got=%0d want=%0d", k, send_cyc[k] - fall_cyc[k-1], GUARD_T + 3);
        end
        n_cmp++;
        if (send_cyc[k] - send_cyc[k-1] != FRAME + GUARD_T + 4) begin
          n_err++; $display("FAIL b2b_spacing%0d got=%0d want=%0d", k, send_cyc[k] - send_cyc[k-1], FRAME + GUARD_T + 4);
        end
      end
    end
    wait_idle(FRAME + GUARD_T + 50, ok);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL b2b_drain_timeout idle=%b want=1", idle); end
    n_cmp++; if (viol != 0) begin n_err++; $display("FAIL b2b_send_while_busy got=%0d want=0", viol); end
  endtask

  task automatic test_no_busy();
    bit ok;
    int unsigned c0;
    clear_log();
    model_en = 1'b0;
    @(negedge clk);
    c0 = cyc;
    wr_en = 1'b1; wr_data = 8'h3C;
    @(negedge clk);
    wr_data = 8'hC3;
    @(negedge clk);
    wr_en = 1'b0;
    for (int unsigned i = 0; i < 2 * (GUARD_T + 20) && sent_q.size() < 2; i++) @(posedge clk);
    n_cmp++; if (sent_q.size() != 2) begin n_err++; $display("FAIL nobusy_count got=%0d want=2", sent_q.size()); end
    if (sent_q.size() == 2) begin
      n_cmp++; if (sent_q[0] !== 8'h3C) begin n_err++; $display("FAIL nobusy_byte0 got=%h want=3c", sent_q[0]); end
      n_cmp++; if (sent_q[1] !== 8'hC3) begin n_err++; $display("FAIL nobusy_byte1 got=%h want=c3", sent_q[1]); end
      n_cmp++; if (send_cyc[0] != c0 + 2) begin n_err++; $display("FAIL nobusy_latency got=%0d want=%0d", send_cyc[0] - c0, 2); end
      // 4 WAIT_HI cycles, 1 WAIT_LO, GUARD+1 guard cycles, 1 IDLE, then send.
      n_cmp++;
      if (send_cyc[1] - send_cyc[0] != GUARD_T + 8) begin
        n_err++; $display("FAIL nobusy_spacing got=%0d want=%0d", send_cyc[1] - send_cyc[0], GUARD_T + 8);
      end
    end
    wait_idle(GUARD_T + 50, ok);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL nobusy_drain_timeout idle=%b want=1", idle); end
    model_en = 1'b1;
  endtask

  task automatic test_overflow();
    clear_log();
    busy_force = 1'b1;
    for (int unsigned k = 0; k < 16; k++) begin
      @(negedge clk);
      wr_en = 1'b1; wr_data = 8'(8'h10 + k);
    end
    @(negedge clk);
    wr_en = 1'b0;
    n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL ovf_full got=%b want=1", full); end
    n_cmp++; if (empty !== 1'b0) begin n_err++; $display("FAIL ovf_empty got=%b want=0", empty); end
    wr_en = 1'b1; wr_data = 8'hFF;
    @(negedge clk);
    wr_en = 1'b0;
    n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL ovf_full_after_drop got=%b want=1", full); end
    n_cmp++; if (sent_q.size() != 0) begin n_err++; $display("FAIL ovf_sent_while_busy got=%0d want=0", sent_q.size()); end
`ifdef UART_TXQ_STATUS_EN
    n_cmp++; if (level !== 5'd16) begin n_err++; $display("FAIL ovf_level got=%0d want=16", level); end
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set got=%b want=1", overflow); end
    ovf_clr = 1'b1; wr_en = 1'b1; wr_data = 8'hEE;
    @(negedge clk);
    wr_en = 1'b0;
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set_wins got=%b want=1", overflow); end
    @(negedge clk);
    ovf_clr = 1'b0;
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clr got=%b want=0", overflow); end
    n_cmp++; if (level !== 5'd16) begin n_err++; $display("FAIL ovf_level_after_clr got=%0d want=16", level); end
`endif
  endtask

  task automatic test_full_wr_pop();
    // queue is full with 10..1F and busy stuck; release busy and write together
    @(negedge clk);
    busy_force = 1'b0;
    wr_en = 1'b1; wr_data = 8'h77;
    @(negedge clk);
    wr_en = 1'b0;
    n_cmp++; if (tx_send !== 1'b1) begin n_err++; $display("FAIL fullpop_send got=%b want=1", tx_send); end
    n_cmp++; if (tx_sbyte !== 8'h10) begin n_err++; $display("FAIL fullpop_head got=%h want=10", tx_sbyte); end
    n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL fullpop_full got=%b want=1", full); end
`ifdef UART_TXQ_STATUS_EN
    n_cmp++; if (level !== 5'd16) begin n_err++; $display("FAIL fullpop_level got=%0d want=16", level); end
`endif
  endtask

  task automatic test_reset_mid_frame();
    bit seen;
    seen = 1'b0;
    for (int unsigned i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx_busy === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    n_cmp++; if (seen !== 1'b1) begin n_err++; $display("FAIL midrst_busy_timeout got=%b want=1", tx_busy); end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    n_cmp++; if (tx_send !== 1'b0) begin n_err++; $display("FAIL midrst_tx_send got=%b want=0", tx_send); end
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL midrst_empty got=%b want=1", empty); end
    n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL midrst_full got=%b want=0", full); end
    n_cmp++; if (idle !== 1'b1) begin n_err++; $display("FAIL midrst_idle got=%b want=1", idle); end
    n_cmp++; if (tx_sbyte !== 8'h00) begin n_err++; $display("FAIL midrst_sbyte got=%h want=00", tx_sbyte); end
    @(negedge clk);
    reset = 1'b0;
    clear_log();
    repeat (2 * (FRAME + GUARD_T)) @(negedge clk);
    n_cmp++; if (sent_q.size() != 0) begin n_err++; $display("FAIL midrst_resend got=%0d want=0", sent_q.size()); end
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL midrst_empty_after got=%b want=1", empty); end
    n_cmp++; if (idle !== 1'b1) begin n_err++; $display("FAIL midrst_idle_after got=%b want=1", idle); end
  endtask

  initial begin
    reset = 1'b1;
    wr_en = 1'b0;
    wr_data = 8'h00;
`ifdef UART_TXQ_STATUS_EN
    ovf_clr = 1'b0;
`endif
    test_reset();
    test_single_latency();
    test_back_to_back();
    test_no_busy();
    test_overflow();
    test_full_wr_pop();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
